datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  request to execute one operation; sampled only in IDLE.
- opcode  in  2  operation: 00 MOV, 01 NOT, 10 LDI, 11 ALU2.
- ra  in  4  source register A index; used by ALU2 only.
- rb  in  4  source register B index.
- rc  in  4  destination register index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- encIn  out  32  one-hot bus source select to the datapath bus.
- reg_in  out  16  one-hot R0..R15 load enables.
- Yin  out  1  Y register load enable.
- ZLOin  out  1  ZLO register load enable.
- MDRin  out  1  MDR load enable.
- readMDR  out  1  MDR input select: 1 = memory data, 0 = bus.
- NOT  out  1  ALU function select: 1 = invert the bus operand.
- op_count  out  16  count of completed operations.
REQ-002 Clock and reset are one clock, clk, and a synchronous active-high reset, clr.
REQ-003 encIn bit map SHALL be:
- bits 0-15: R0-R15.
- 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN.
- bits 24-31 always 0.

Function
REQ-004 The FSM states SHALL be IDLE, S1, S2, S3, DONE, held in a registered state variable.
REQ-005 In IDLE with start=1, the block SHALL latch opcode/ra/rb/rc into internal registers and move to S1; the latched values SHALL stay constant until the next return to IDLE.
REQ-006 start while not in IDLE SHALL be ignored: no queueing and no effect on the latched operands.
REQ-007 Control outputs SHALL be decoded from state and latched operands only, never from live inputs. In every state, any output not listed below SHALL be 0.
REQ-008 MOV: S1 drives encIn[rb] and reg_in[rc], then goes to DONE.
REQ-009 NOT:
- S1 drives encIn[rb], NOT=1, ZLOin=1.
- S2 drives encIn[19] and reg_in[rc].
- Then DONE.
REQ-010 LDI:
- S1 drives readMDR=1 and MDRin=1.
- S2 drives encIn[21] and reg_in[rc].
- Then DONE.
REQ-011 ALU2:
- S1 drives encIn[ra] and Yin=1.
- S2 drives encIn[rb], ZLOin=1, NOT=0.
- S3 drives encIn[19] and reg_in[rc].
- Then DONE.
REQ-012 DONE SHALL assert done=1 for exactly one cycle, increment op_count by 1, and return to IDLE unconditionally.
REQ-013 op_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-014 Latency from the start-sampling edge to the done-high cycle SHALL be: MOV 2, NOT 3, LDI 3, ALU2 4 cycles.
REQ-015 Back-to-back operation: start high during the DONE cycle SHALL be ignored; start is accepted in the following IDLE cycle, giving a minimum issue interval of latency+1.
REQ-016 encIn SHALL have at most one bit set and reg_in at most one bit set in any cycle. Both are all-zero in IDLE and DONE.
REQ-017 Source equal to destination (for example rb==rc in MOV) SHALL execute normally with no special casing.

Reset
REQ-018 With clr=1 at a rising edge, the block SHALL, regardless of state (including mid-operation):
- go to IDLE;
- clear the latched operands and op_count to 0;
- leave busy=0, done=0, and all control outputs 0 in the following cycle.
REQ-019 clr SHALL take priority over start in the same cycle, and an operation interrupted by clr SHALL NOT produce done or increment op_count.

Verification
REQ-020 MOV r3<-r5: start with opcode=00, rb=5, rc=3 -> cycle 1 encIn=32'h20 and reg_in=16'h0008; cycle 2 done=1; op_count=1.
REQ-021 NOT r7<-~r2: -> S1 encIn=32'h4, NOT=1, ZLOin=1; S2 encIn=32'h80000, reg_in=16'h0080; done at cycle 3.
REQ-022 ALU2 ra=1, rb=2, rc=4: -> Yin with encIn=32'h2; then ZLOin with encIn=32'h4; then encIn=32'h80000 with reg_in=16'h0010; done at cycle 4; start pulses during busy are ignored.
REQ-023 LDI rc=15: -> S1 readMDR=1, MDRin=1; S2 encIn=32'h200000, reg_in=16'h8000; done at cycle 3.
REQ-024 clr asserted in S2 of ALU2 -> next cycle IDLE, all outputs 0, op_count=0, and no done pulse.
REQ-025 Preload op_count=16'hFFFF via 65535 MOVs, then one more MOV -> op_count=16'h0000.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Purpose: control sequencer for a single-bus datapath; runs MOV/NOT/LDI/ALU2 as 1-3 control steps plus a DONE step.
// Latency: start-sampling edge to done-high cycle is MOV 2, NOT/LDI 3, ALU2 4 cycles; every control output is registered.
// Backpressure: none; start is sampled only in IDLE and ignored otherwise, so the minimum issue interval is latency+1.
//
// Ports:
//   clk, clr            clock and synchronous active-high reset
//   start, opcode       operation request (00 MOV, 01 NOT, 10 LDI, 11 ALU2)
//   ra, rb, rc          source A, source B and destination register indices
//   busy, done          high outside IDLE / one-cycle completion pulse
//   encIn               one-hot bus source select (0-15 R0-R15, 19 ZLO, 21 MDR, 24-31 unused)
//   reg_in              one-hot R0..R15 load enables
//   Yin, ZLOin, MDRin   Y, ZLO and MDR load enables
//   readMDR, NOT        MDR input select (1 = memory) and ALU invert select
//   op_count            completed-operation count, wraps silently
`timescale 1ns/1ps
module datapath_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    output logic        busy,
    output logic        done,
    output logic [31:0] encIn,
    output logic [15:0] reg_in,
    output logic        Yin,
    output logic        ZLOin,
    output logic        MDRin,
    output logic        readMDR,
    output logic        NOT,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_NOT  = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_ALU2 = 2'b11;

    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_MDR = 5'd21;

    state_t      state, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

    logic [31:0] enc_d;
    logic [15:0] reg_d;
    logic        yin_d, zlo_d, mdrin_d, rdmdr_d, not_d;

    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        return 32'(1) << idx;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    // Next state and operand latch. Operands only change on the IDLE->S1
    // transition, so a start seen while busy cannot disturb them.
    always_comb begin
        state_d = state;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = S1;
                    op_d    = opcode;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                end
            end
            S1:      state_d = (op_q == OP_MOV)  ? DONE : S2;
            S2:      state_d = (op_q == OP_ALU2) ? S3   : DONE;
            S3:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decode for the step about to be entered; registering it
    // makes the outputs a clean function of the (registered) state and
    // latched operands in the cycle they apply.
    always_comb begin
        enc_d   = '0;
        reg_d   = '0;
        yin_d   = 1'b0;
        zlo_d   = 1'b0;
        mdrin_d = 1'b0;
        rdmdr_d = 1'b0;
        not_d   = 1'b0;
        case (state_d)
            S1: begin
                case (op_d)
                    OP_MOV: begin
                        enc_d = onehot32({1'b0, rb_d});
                        reg_d = onehot16(rc_d);
                    end
                    OP_NOT: begin
                        enc_d = onehot32({1'b0, rb_d});
                        not_d = 1'b1;
                        zlo_d = 1'b1;
                    end
                    OP_LDI: begin
                        rdmdr_d = 1'b1;
                        mdrin_d = 1'b1;
                    end
                    default: begin
                        enc_d = onehot32({1'b0, ra_d});
                        yin_d = 1'b1;
                    end
                endcase
            end
            S2: begin
                case (op_d)
                    OP_NOT: begin
                        enc_d = onehot32(SEL_ZLO);
                        reg_d = onehot16(rc_d);
                    end
                    OP_LDI: begin
                        enc_d = onehot32(SEL_MDR);
                        reg_d = onehot16(rc_d);
                    end
                    OP_ALU2: begin
                        enc_d = onehot32({1'b0, rb_d});
                        zlo_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S3: begin
                // Only ALU2 reaches S3: write the ALU result back.
                enc_d = onehot32(SEL_ZLO);
                reg_d = onehot16(rc_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            op_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            encIn    <= '0;
            reg_in   <= '0;
            Yin      <= 1'b0;
            ZLOin    <= 1'b0;
            MDRin    <= 1'b0;
            readMDR  <= 1'b0;
            NOT      <= 1'b0;
        end else begin
            state    <= state_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            // Count on leaving DONE, so an operation cut short by clr is never counted.
            if (state == DONE)
                op_count <= op_count + 16'd1;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            encIn    <= enc_d;
            reg_in   <= reg_d;
            Yin      <= yin_d;
            ZLOin    <= zlo_d;
            MDRin    <= mdrin_d;
            readMDR  <= rdmdr_d;
            NOT      <= not_d;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Purpose: directed self-checking bench for datapath_sequencer.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: n/a; each step is a fixed number of cycles, so the run always ends.
`timescale 1ns/1ps
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'b00;
    logic [3:0]  ra = 4'd0, rb = 4'd0, rc = 4'd0;
    logic        busy, done, Yin, ZLOin, MDRin, readMDR, not_sel;
    logic [31:0] encIn;
    logic [15:0] reg_in, op_count;

    int tests = 0;
    int fails = 0;

    // {busy, done, Yin, ZLOin, MDRin, readMDR, NOT}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_BUSY = 7'b1000000;
    localparam logic [6:0] C_DONE = 7'b1100000;
    localparam logic [6:0] C_Y    = 7'b1010000;
    localparam logic [6:0] C_ZLO  = 7'b1001000;
    localparam logic [6:0] C_NOT  = 7'b1001001;
    localparam logic [6:0] C_LDI  = 7'b1000110;

    datapath_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc),
        .busy(busy), .done(done), .encIn(encIn), .reg_in(reg_in),
        .Yin(Yin), .ZLOin(ZLOin), .MDRin(MDRin), .readMDR(readMDR),
        .NOT(not_sel), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare all control outputs in the current cycle.
    task automatic cyc(input string tag, input logic [31:0] enc, input logic [15:0] rg, input logic [6:0] ctl);
        chk({tag, ".encIn"},  encIn, enc);
        chk({tag, ".reg_in"}, {16'd0, reg_in}, {16'd0, rg});
        chk({tag, ".ctrl"},   {25'd0, busy, done, Yin, ZLOin, MDRin, readMDR, not_sel}, {25'd0, ctl});
    endtask

    // Present a request for one cycle; returns at the falling edge of cycle 1 (first step).
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    initial begin
        tick; tick;
        clr = 1'b0;
        tick;
        cyc("reset", 32'h0, 16'h0, C_IDLE);
        chk("reset.op_count", {16'd0, op_count}, 32'd0);

        // MOV r3 <- r5, live inputs scrambled and start pulsed while busy.
        issue(2'b00, 4'd9, 4'd5, 4'd3);
        opcode = 2'b11; ra = 4'd14; rb = 4'd13; rc = 4'd12; start = 1'b1;
        cyc("mov.s1", 32'h20, 16'h0008, C_BUSY);
        tick;
        cyc("mov.done", 32'h0, 16'h0, C_DONE);
        start = 1'b0;
        tick;
        cyc("mov.idle", 32'h0, 16'h0, C_IDLE);
        chk("mov.op_count", {16'd0, op_count}, 32'd1);

        // NOT r7 <- ~r2
        issue(2'b01, 4'd0, 4'd2, 4'd7);
        cyc("not.s1", 32'h4, 16'h0, C_NOT);
        tick;
        cyc("not.s2", 32'h80000, 16'h0080, C_BUSY);
        tick;
        cyc("not.done", 32'h0, 16'h0, C_DONE);
        tick;
        cyc("not.idle", 32'h0, 16'h0, C_IDLE);
        chk("not.op_count", {16'd0, op_count}, 32'd2);

        // ALU2 ra=1 rb=2 rc=4 with start pulses and new operands while busy.
        issue(2'b11, 4'd1, 4'd2, 4'd4);
        opcode = 2'b00; ra = 4'd8; rb = 4'd9; rc = 4'd10; start = 1'b1;
        cyc("alu.s1", 32'h2, 16'h0, C_Y);
        tick;
        start = 1'b0;
        cyc("alu.s2", 32'h4, 16'h0, C_ZLO);
        tick;
        start = 1'b1;
        cyc("alu.s3", 32'h80000, 16'h0010, C_BUSY);
        tick;
        cyc("alu.done", 32'h0, 16'h0, C_DONE);
        start = 1'b0;
        tick;
        cyc("alu.idle", 32'h0, 16'h0, C_IDLE);
        chk("alu.op_count", {16'd0, op_count}, 32'd3);

        // LDI r15
        issue(2'b10, 4'd0, 4'd0, 4'd15);
        cyc("ldi.s1", 32'h0, 16'h0, C_LDI);
        tick;
        cyc("ldi.s2", 32'h200000, 16'h8000, C_BUSY);
        tick;
        cyc("ldi.done", 32'h0, 16'h0, C_DONE);
        tick;
        cyc("ldi.idle", 32'h0, 16'h0, C_IDLE);
        chk("ldi.op_count", {16'd0, op_count}, 32'd4);

        // MOV r6 <- r6: source equals destination.
        issue(2'b00, 4'd0, 4'd6, 4'd6);
        cyc("movsame.s1", 32'h40, 16'h0040, C_BUSY);
        tick;
        cyc("movsame.done", 32'h0, 16'h0, C_DONE);
        tick;
        chk("movsame.op_count", {16'd0, op_count}, 32'd5);

        // Back-to-back: start held high; accepted only in the IDLE after DONE.
        opcode = 2'b00; ra = 4'd0; rb = 4'd0; rc = 4'd1; start = 1'b1;
        tick;
        cyc("b2b.s1a", 32'h1, 16'h0002, C_BUSY);
        tick;
        cyc("b2b.donea", 32'h0, 16'h0, C_DONE);
        tick;
        cyc("b2b.idle", 32'h0, 16'h0, C_IDLE);
        chk("b2b.op_count_a", {16'd0, op_count}, 32'd6);
        tick;
        start = 1'b0;
        cyc("b2b.s1b", 32'h1, 16'h0002, C_BUSY);
        tick;
        cyc("b2b.doneb", 32'h0, 16'h0, C_DONE);
        tick;
        chk("b2b.op_count_b", {16'd0, op_count}, 32'd7);

        // clr during S2 of ALU2, then clr and start together in IDLE.
        issue(2'b11, 4'd3, 4'd4, 4'd5);
        cyc("clr.s1", 32'h8, 16'h0, C_Y);
        tick;
        cyc("clr.s2", 32'h10, 16'h0, C_ZLO);
        clr = 1'b1; start = 1'b1;
        tick;
        cyc("clr.after", 32'h0, 16'h0, C_IDLE);
        chk("clr.op_count", {16'd0, op_count}, 32'd0);
        tick;
        cyc("clr.prio", 32'h0, 16'h0, C_IDLE);
        clr = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            cyc("clr.nodone", 32'h0, 16'h0, C_IDLE);
        end
        chk("clr.op_count_hold", {16'd0, op_count}, 32'd0);

        // Counter wrap: preload near full scale instead of running 65535 operations.
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        tick;
        chk("wrap.preload", {16'd0, op_count}, 32'h0000FFFE);
        issue(2'b00, 4'd0, 4'd2, 4'd3);
        tick; tick;
        chk("wrap.ffff", {16'd0, op_count}, 32'h0000FFFF);
        issue(2'b00, 4'd0, 4'd2, 4'd3);
        tick;
        cyc("wrap.done", 32'h0, 16'h0, C_DONE);
        tick;
        chk("wrap.zero", {16'd0, op_count}, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
